// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared types and constants for the tug-of-war match controller
package tug_pkg;

    localparam int LFSR_W           = 9;
    localparam int SCORE_W          = 3;
    localparam int CD_W             = 8;
    localparam int MATCH_POINTS_DEF = 7;
    localparam int COOLDOWN_DEF     = 8;

    typedef enum logic [1:0] {
        ROUND_START = 2'd0,
        PLAY        = 2'd1,
        ROUND_END   = 2'd2,
        MATCH_OVER  = 2'd3
    } tug_state_t;

endpackage

// File: rtl/ai_press_gen.sv
// rtl/ai_press_gen.sv - LFSR-driven AI press generator with difficulty threshold
module ai_press_gen
    import tug_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Tick,
    input  logic              Enable,
    input  logic [LFSR_W-1:0] Difficulty,
    output logic              Press
);

    logic [LFSR_W-1:0] lfsr;

    // XNOR feedback keeps the all-zero reset value a legal running state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            lfsr <= '0;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], ~(lfsr[LFSR_W-1] ^ lfsr[4])};
        end
    end

    // Difficulty 0 can never exceed the LFSR, so the AI stays silent
    assign Press = Enable & Tick & (lfsr < Difficulty);

endmodule

// File: rtl/tug_match_controller.sv
// rtl/tug_match_controller.sv - round/match sequencing, scoring and move gating
module tug_match_controller
    import tug_pkg::*;
#(
    parameter int MATCH_POINTS = MATCH_POINTS_DEF,
    parameter int COOLDOWN     = COOLDOWN_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               PressL,
    input  logic               PressR,
    input  logic               AiEnable,
    input  logic               Tick,
    input  logic [LFSR_W-1:0]  Difficulty,
    input  logic               WinL,
    input  logic               WinR,
    input  logic               NewMatch,
    output logic               MoveL,
    output logic               MoveR,
    output logic               FieldReset,
    output logic [SCORE_W-1:0] ScoreL,
    output logic [SCORE_W-1:0] ScoreR,
    output logic               MatchOver,
    output logic               Winner
);

    localparam logic [SCORE_W-1:0] MP      = SCORE_W'(MATCH_POINTS);
    localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN - 1);

    tug_state_t         state, state_next;
    logic [SCORE_W-1:0] score_l, score_l_next;
    logic [SCORE_W-1:0] score_r, score_r_next;
    logic [CD_W-1:0]    cooldown, cooldown_next;
    logic               ai_press;
    logic               in_play;

    ai_press_gen u_ai (
        .Clock      (Clock),
        .Reset      (Reset),
        .Tick       (Tick),
        .Enable     (AiEnable),
        .Difficulty (Difficulty),
        .Press      (ai_press)
    );

    // State, score and cooldown registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ROUND_START;
            score_l  <= '0;
            score_r  <= '0;
            cooldown <= '0;
        end else begin
            state    <= state_next;
            score_l  <= score_l_next;
            score_r  <= score_r_next;
            cooldown <= cooldown_next;
        end
    end

    // Next-state, scoring and cooldown sequencing; a tie on the win inputs is no win
    always_comb begin
        state_next    = state;
        score_l_next  = score_l;
        score_r_next  = score_r;
        cooldown_next = cooldown;
        case (state)
            ROUND_START: begin
                state_next = PLAY;
            end
            PLAY: begin
                if (WinL && !WinR) begin
                    if (score_l < MP) score_l_next = score_l + SCORE_W'(1);
                    cooldown_next = CD_LOAD;
                    state_next    = ROUND_END;
                end else if (WinR && !WinL) begin
                    if (score_r < MP) score_r_next = score_r + SCORE_W'(1);
                    cooldown_next = CD_LOAD;
                    state_next    = ROUND_END;
                end
            end
            ROUND_END: begin
                if (cooldown == '0) begin
                    state_next = (score_l == MP || score_r == MP) ? MATCH_OVER : ROUND_START;
                end else begin
                    cooldown_next = cooldown - CD_W'(1);
                end
            end
            MATCH_OVER: begin
                if (NewMatch) begin
                    score_l_next = '0;
                    score_r_next = '0;
                    state_next   = ROUND_START;
                end
            end
            default: begin
                state_next = ROUND_START;
            end
        endcase
    end

    // Reset forces the idle output pattern immediately, before the next edge
    assign in_play    = (state == PLAY) && !Reset;
    assign MoveL      = in_play && (AiEnable ? ai_press : PressL);
    assign MoveR      = in_play && PressR;
    assign FieldReset = Reset || (state == ROUND_START);
    assign MatchOver  = !Reset && (state == MATCH_OVER);
    assign Winner     = MatchOver && (score_l == MP);
    assign ScoreL     = score_l;
    assign ScoreR     = score_r;

endmodule

// File: tb/tb_tug_match_controller.sv
// tb/tb_tug_match_controller.sv - self-checking bench with behavioural match model
module tb_tug_match_controller;

    localparam int MP = 7;
    localparam int CD = 8;
    localparam int P_START = 0, P_PLAY = 1, P_END = 2, P_OVER = 3;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       PressL = 1'b0, PressR = 1'b0, AiEnable = 1'b0, Tick = 1'b0;
    logic [8:0] Difficulty = 9'd0;
    logic       WinL = 1'b0, WinR = 1'b0, NewMatch = 1'b0;
    logic       MoveL, MoveR, FieldReset, MatchOver, Winner;
    logic [2:0] ScoreL, ScoreR;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model
    int m_phase = P_START;
    int m_sl = 0, m_sr = 0, m_left = 0, m_lfsr = 0;
    bit started = 1'b0;
    int ai_moves = 0;

    tug_match_controller #(.MATCH_POINTS(MP), .COOLDOWN(CD)) u_dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .PressL     (PressL),
        .PressR     (PressR),
        .AiEnable   (AiEnable),
        .Tick       (Tick),
        .Difficulty (Difficulty),
        .WinL       (WinL),
        .WinR       (WinR),
        .NewMatch   (NewMatch),
        .MoveL      (MoveL),
        .MoveR      (MoveR),
        .FieldReset (FieldReset),
        .ScoreL     (ScoreL),
        .ScoreR     (ScoreR),
        .MatchOver  (MatchOver),
        .Winner     (Winner)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    function automatic int lfsr_next(input int v);
        int b8, b4;
        b8 = (v >> 8) & 1;
        b4 = (v >> 4) & 1;
        return ((v << 1) & 9'h1FE) | ((b8 ^ b4) ? 0 : 1);
    endfunction

    // model advances on each rising edge from the inputs seen at that edge
    always @(posedge Clock) begin
        started = 1'b1;
        if (Reset) begin
            m_phase = P_START; m_sl = 0; m_sr = 0; m_left = 0; m_lfsr = 0;
        end else begin
            m_lfsr = lfsr_next(m_lfsr);
            case (m_phase)
                P_START: m_phase = P_PLAY;
                P_PLAY: begin
                    if (WinL && !WinR) begin
                        m_sl = (m_sl < MP) ? m_sl + 1 : MP; m_left = CD; m_phase = P_END;
                    end else if (WinR && !WinL) begin
                        m_sr = (m_sr < MP) ? m_sr + 1 : MP; m_left = CD; m_phase = P_END;
                    end
                end
                P_END: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = (m_sl == MP || m_sr == MP) ? P_OVER : P_START;
                end
                default: begin
                    if (NewMatch) begin m_sl = 0; m_sr = 0; m_phase = P_START; end
                end
            endcase
        end
    end

    // compare all outputs against the model midway through every cycle
    always @(negedge Clock) begin
        if (started) begin
            bit play, exp_ml;
            play   = !Reset && m_phase == P_PLAY;
            exp_ml = play && (AiEnable ? (Tick && m_lfsr < int'(Difficulty)) : PressL);
            chk("model_move_l", int'(MoveL), int'(exp_ml));
            chk("model_move_r", int'(MoveR), int'(play && PressR));
            chk("model_field_reset", int'(FieldReset), int'(Reset || m_phase == P_START));
            chk("model_score_l", int'(ScoreL), m_sl);
            chk("model_score_r", int'(ScoreR), m_sr);
            chk("model_match_over", int'(MatchOver), int'(!Reset && m_phase == P_OVER));
            chk("model_winner", int'(Winner), int'(!Reset && m_phase == P_OVER && m_sl == MP));
            if (AiEnable && MoveL) ai_moves++;
        end
    end

    task automatic wait_play();
        for (int i = 0; i < 40; i++) begin
            if (m_phase == P_PLAY) break;
            step(1);
        end
        chk("reach_play", m_phase, P_PLAY);
    endtask

    task automatic win_left();
        wait_play();
        WinL = 1'b1;
        step(1);
        WinL = 1'b0;
    endtask

    initial begin
        step(3);
        Reset = 1'b0;
        @(negedge Clock);
        chk("first_cycle_field_reset", int'(FieldReset), 1);
        chk("reset_score_l", int'(ScoreL), 0);
        step(1);
        @(negedge Clock);
        chk("play_field_reset_low", int'(FieldReset), 0);
        step(1);
        PressR = 1'b1;
        @(negedge Clock);
        chk("press_r_passthrough", int'(MoveR), 1);
        step(1);

        // simultaneous presses and simultaneous wins
        PressL = 1'b1;
        @(negedge Clock);
        chk("both_moves_l", int'(MoveL), 1);
        chk("both_moves_r", int'(MoveR), 1);
        step(1);
        PressL = 1'b0; PressR = 1'b0;
        WinL = 1'b1; WinR = 1'b1;
        step(1);
        WinL = 1'b0; WinR = 1'b0;
        PressR = 1'b1;
        @(negedge Clock);
        chk("tie_win_score_l", int'(ScoreL), 0);
        chk("tie_win_score_r", int'(ScoreR), 0);
        chk("tie_win_still_play", int'(MoveR), 1);
        step(1);

        // right round win and cooldown window
        WinR = 1'b1;
        step(1);
        WinR = 1'b0;
        for (int k = 1; k <= CD; k++) begin
            @(negedge Clock);
            chk("cooldown_move_r_blocked", int'(MoveR), 0);
            chk("cooldown_no_field_reset", int'(FieldReset), 0);
            if (k == 1) chk("win_r_score", int'(ScoreR), 1);
            step(1);
        end
        @(negedge Clock);
        chk("field_reset_after_cooldown", int'(FieldReset), 1);
        PressR = 1'b0;
        step(1);

        // seven left wins decide the match
        for (int w = 0; w < MP; w++) win_left();
        @(negedge Clock);
        chk("seventh_win_score_l", int'(ScoreL), 7);
        step(CD);
        @(negedge Clock);
        chk("match_over_flag", int'(MatchOver), 1);
        chk("match_winner_left", int'(Winner), 1);
        chk("match_over_score_r", int'(ScoreR), 1);
        WinL = 1'b1;
        step(3);
        WinL = 1'b0;
        @(negedge Clock);
        chk("score_l_saturates", int'(ScoreL), 7);
        NewMatch = 1'b1;
        step(1);
        NewMatch = 1'b0;
        @(negedge Clock);
        chk("new_match_score_l", int'(ScoreL), 0);
        chk("new_match_score_r", int'(ScoreR), 0);
        chk("new_match_field_reset", int'(FieldReset), 1);
        step(1);

        // AI with zero difficulty never presses, PressL ignored
        AiEnable = 1'b1; Tick = 1'b1; Difficulty = 9'd0;
        ai_moves = 0;
        for (int i = 0; i < 600; i++) begin
            PressL = 1'($urandom_range(0, 1));
            step(1);
        end
        chk("ai_difficulty_zero_moves", ai_moves, 0);

        // AI at full difficulty and a mid threshold with random Tick
        Difficulty = 9'd511;
        ai_moves = 0;
        for (int i = 0; i < 100; i++) begin
            Tick = 1'($urandom_range(0, 1));
            PressL = 1'($urandom_range(0, 1));
            step(1);
        end
        chk("ai_full_difficulty_moves", int'(ai_moves > 0), 1);
        Difficulty = 9'd150;
        for (int i = 0; i < 100; i++) begin
            Tick = 1'($urandom_range(0, 1));
            step(1);
        end
        AiEnable = 1'b0; Tick = 1'b0; PressL = 1'b0; Difficulty = 9'd0;

        // reset in the fourth cooldown cycle with ScoreL = 3
        for (int w = 0; w < 3; w++) win_left();
        step(3);
        @(negedge Clock);
        chk("pre_reset_score_l", int'(ScoreL), 3);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        @(negedge Clock);
        chk("abort_score_l", int'(ScoreL), 0);
        chk("abort_field_reset", int'(FieldReset), 1);
        chk("abort_lfsr", int'(u_dut.u_ai.lfsr), 0);
        step(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
